ps2_kbd_tx: RTL and testbench

PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

---
 rtl/ps2_defs.sv | 34 +++
 rtl/ps2_tx_fifo.sv | 55 +++++
 rtl/ps2_kbd_tx.sv | 155 +++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_defs.sv
// PS/2 frame constants and device-side transmitter state encodings; shared with the PS/2 receiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ps2_defs;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HIGH  = 3'd1,
    ST_LOW   = 3'd2,
    ST_GAP   = 3'd3,
    ST_ABORT = 3'd4
  } ps2_state_e;

  localparam int PS2_FRAME_BITS  = 11;  // start + 8 data + parity + stop
  localparam int PS2_DEF_CLK_DIV = 32;
  localparam int PS2_DEF_GAP_CYC = 64;
  localparam int PS2_CNT_W       = 10;  // holds 1023 without wrap
  localparam int PS2_IDX_W       = 4;

  // Line level for frame bit idx of byte data: 0 start, 1..8 data LSB first,
  // 9 odd parity, 10 stop.
  function automatic logic ps2_frame_bit(input logic [7:0] data,
                                         input logic [PS2_IDX_W-1:0] idx);
    logic b;
    case (idx)
      4'd0:    b = 1'b0;
      4'd9:    b = ~^data;
      4'd10:   b = 1'b1;
      default: b = (idx <= 4'd8) ? data[3'(idx - 4'd1)] : 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Small synchronous FIFO holding scancode bytes waiting to be framed.
// Latency: a pushed word is visible on pop_dat_o the cycle after the push edge.
// Backpressure: full_o blocks pushes, empty_o blocks pops; a simultaneous push and pop both take effect.
// Ports: push_i/push_dat_i write side, pop_i/pop_dat_o read side (show-ahead), full_o/empty_o status.
module ps2_tx_fifo #(
  parameter int DEPTH = 4,  // power of two so the pointers wrap naturally
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (cnt_q == FULL_CNT);
  assign empty_o   = (cnt_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: queues scancode bytes and sends each as an 11-bit device-clocked frame.
// Latency: ps2_data falls on the second clk edge after a byte is accepted into an idle, empty block.
// Backpressure: in_ready drops while the 4-entry queue is full; host inhibit stalls or aborts-and-resends a frame.
// Ports: in_data/in_valid/in_ready byte input, ps2_inhibit host clock hold, ps2_clk/ps2_data registered lines, busy.
module ps2_kbd_tx
  import ps2_defs::*;
#(
  parameter int CLK_DIV = PS2_DEF_CLK_DIV,
  parameter int GAP_CYC = PS2_DEF_GAP_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       ps2_inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam logic [PS2_CNT_W-1:0] DIV_LAST = PS2_CNT_W'(CLK_DIV - 1);
  localparam logic [PS2_CNT_W-1:0] GAP_LAST = PS2_CNT_W'(GAP_CYC - 1);
  localparam logic [PS2_IDX_W-1:0] STOP_IDX = PS2_IDX_W'(PS2_FRAME_BITS - 1);

  ps2_state_e           state_q;
  logic [PS2_CNT_W-1:0] cnt_q;
  logic [PS2_IDX_W-1:0] idx_q;
  logic [7:0]           hold_q;
  logic                 retx_q;      // held byte was aborted and must be resent
  logic                 ne_q;        // FIFO non-empty, delayed one cycle
  logic                 ps2_clk_q;
  logic                 ps2_data_q;

  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dat;
  logic       gap_done;
  logic       start_go;
  logic       can_abort;
  logic [7:0] start_byte;

  ps2_tx_fifo #(
    .DEPTH (4),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_dat_i (in_data),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign ps2_clk   = ps2_clk_q;
  assign ps2_data  = ps2_data_q;

  // A frame can start from IDLE or straight out of the last GAP cycle, so
  // back-to-back frames are separated by exactly GAP_CYC high cycles.
  // ne_q (not the live empty flag) provides the one-cycle start delay.
  assign gap_done   = (state_q == ST_GAP) && (cnt_q == GAP_LAST);
  assign start_go   = ((state_q == ST_IDLE) || gap_done) && !ps2_inhibit && (retx_q || ne_q);
  assign fifo_pop   = start_go && !retx_q;
  assign start_byte = retx_q ? hold_q : fifo_dat;
  // Inhibit during the stop bit is ignored: the frame is already delivered.
  assign can_abort  = ps2_inhibit && (idx_q < STOP_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      hold_q     <= '0;
      retx_q     <= 1'b0;
      ne_q       <= 1'b0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
    end else begin
      ne_q <= !fifo_empty;
      if (start_go) begin
        state_q    <= ST_HIGH;
        cnt_q      <= '0;
        idx_q      <= '0;
        hold_q     <= start_byte;
        retx_q     <= 1'b0;
        ps2_clk_q  <= 1'b1;
        ps2_data_q <= ps2_frame_bit(start_byte, '0);
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
          end
          ST_HIGH: begin
            if (can_abort) begin
              state_q    <= ST_ABORT;
              ps2_clk_q  <= 1'b1;
              ps2_data_q <= 1'b1;
            end else if (cnt_q == DIV_LAST) begin
              state_q   <= ST_LOW;
              cnt_q     <= '0;
              ps2_clk_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + PS2_CNT_W'(1);
            end
          end
          ST_LOW: begin
            if (can_abort) begin
              state_q    <= ST_ABORT;
              ps2_clk_q  <= 1'b1;
              ps2_data_q <= 1'b1;
            end else if (cnt_q == DIV_LAST) begin
              cnt_q     <= '0;
              ps2_clk_q <= 1'b1;
              if (idx_q == STOP_IDX) begin
                state_q    <= ST_GAP;
                ps2_data_q <= 1'b1;
              end else begin
                state_q    <= ST_HIGH;
                idx_q      <= idx_q + PS2_IDX_W'(1);
                ps2_data_q <= ps2_frame_bit(hold_q, idx_q + PS2_IDX_W'(1));
              end
            end else begin
              cnt_q <= cnt_q + PS2_CNT_W'(1);
            end
          end
          ST_GAP: begin
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            if (gap_done) state_q <= ST_IDLE;
            else          cnt_q   <= cnt_q + PS2_CNT_W'(1);
          end
          ST_ABORT: begin
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            if (!ps2_inhibit) begin
              state_q <= ST_GAP;
              cnt_q   <= '0;
              retx_q  <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: cycle-level timeline model plus a line-level frame decoder.
// Latency: n/a (testbench).
// Backpressure: byte driver honours in_ready; random host inhibit bursts exercise abort/resend.
module tb_ps2_kbd_tx;

  localparam int D = 4;  // CLK_DIV
  localparam int G = 8;  // GAP_CYC

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       ps2_inhibit = 1'b0;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  ps2_kbd_tx #(.CLK_DIV(D), .GAP_CYC(G)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ps2_inhibit (ps2_inhibit),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural model (absolute cycle timeline) ----------------
  typedef struct { logic [7:0] b; int acc; } ent_t;
  ent_t       mq[$];
  int         m_mode;   // 0 idle, 1 framing, 2 gap, 3 aborted
  int         m_fs;     // edge on which the current frame's start bit appeared
  int         m_gs;     // edge on which the gap began
  logic [7:0] m_held;
  bit         m_retx;
  logic       e_clk = 1'b1, e_dat = 1'b1, e_rdy = 1'b1, e_busy = 1'b0;

  function automatic logic fbit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9) return ~^b;
    return 1'b1;
  endfunction

  task automatic m_start();
    if (!m_retx) begin
      m_held = mq[0].b;
      mq.delete(0);
    end
    m_retx = 1'b0;
    m_mode = 1;
    m_fs   = cyc;
  endtask

  always @(posedge clk) begin : model
    bit acc;
    bit can;
    int j;
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      m_mode = 0;
      m_retx = 1'b0;
      m_held = 8'h00;
    end else begin
      acc = in_valid && (mq.size() < 4);
      // a queued byte may start once it has been in the queue for two edges
      can = !ps2_inhibit && (m_retx || (mq.size() > 0 && mq[0].acc <= cyc - 2));
      case (m_mode)
        0: if (can) m_start();
        1: begin
          j = cyc - 1 - m_fs;
          if (ps2_inhibit && (j / (2*D)) < 10) m_mode = 3;
          else if (cyc - m_fs == 22*D) begin m_mode = 2; m_gs = cyc; end
        end
        2: if (cyc - m_gs == G) begin
          if (can) m_start(); else m_mode = 0;
        end
        default: if (!ps2_inhibit) begin m_mode = 2; m_gs = cyc; m_retx = 1'b1; end
      endcase
      if (acc) mq.push_back('{b: in_data, acc: cyc});
    end
    if (m_mode == 1) begin
      j = cyc - m_fs;
      e_clk = ((j / D) % 2) == 0;
      e_dat = fbit(m_held, j / (2*D));
    end else begin
      e_clk = 1'b1;
      e_dat = 1'b1;
    end
    e_rdy  = mq.size() < 4;
    e_busy = (m_mode != 0) || (mq.size() > 0);
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("ps2_clk", ps2_clk, e_clk);
      chk("ps2_data", ps2_data, e_dat);
      chk("in_ready", in_ready, e_rdy);
      chk("busy", busy, e_busy);
    end
  end

  // ---------------- line monitor / frame decoder ----------------
  logic        pc = 1'b1, pd = 1'b1;
  bit          mon_in_fr = 1'b0;
  int          mon_falls = 0;
  logic [10:0] mon_bits = '0;
  int          mon_start = 0;
  int          nstarts = 0, nfalls_total = 0, nframes = 0;
  logic [7:0]  fr_b[$];
  logic [10:0] fr_bits[$];
  int          fr_len[$], fr_start[$], fr_end[$];

  always @(negedge clk) begin
    if (rst) begin
      pc = 1'b1; pd = 1'b1; mon_in_fr = 1'b0; mon_falls = 0;
    end else begin
      if (pc && ps2_clk && pd && !ps2_data) begin
        mon_in_fr = 1'b1; mon_falls = 0; mon_start = cyc; nstarts++;
      end
      if (pc && !ps2_clk) begin
        if (mon_falls < 11) mon_bits[mon_falls] = ps2_data;
        mon_falls++;
        nfalls_total++;
      end
      if (!pc && ps2_clk && mon_in_fr && mon_falls == 11) begin
        fr_b.push_back(mon_bits[8:1]);
        fr_bits.push_back(mon_bits);
        fr_len.push_back(cyc - mon_start);
        fr_start.push_back(mon_start);
        fr_end.push_back(cyc);
        nframes++;
        mon_in_fr = 1'b0;
      end
      pc = ps2_clk;
      pd = ps2_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_byte(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 3000) begin @(negedge clk); n++; end
    if (!in_ready) fail_to("push_wait");
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (nframes < n && k < budget) begin @(posedge clk); k++; end
    if (nframes < n) fail_to("frame_wait");
  endtask

  task automatic wait_line(input int falls, input logic clk_lvl, input int budget);
    int k;
    k = 0;
    do begin @(negedge clk); #1; k++; end
    while (!(mon_in_fr && mon_falls == falls && ps2_clk == clk_lvl) && k < budget);
    if (!(mon_in_fr && mon_falls == falls && ps2_clk == clk_lvl)) fail_to("line_wait");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int a, rel, n0, s0, f0, base;
    logic [7:0] sent[$];
    bit rnd_on;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk", ps2_clk, 1'b1);
    chk("rst_data", ps2_data, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    rst = 1'b0;
    chk_en = 1'b1;

    // single 0x1C: start bit two edges after acceptance, 88-cycle frame
    push_byte(8'h1C, a);
    wait_frames(1, 400);
    chk("f1c_byte", fr_b[0], 8'h1C);
    chk("f1c_bits", fr_bits[0], 11'h438);
    chk("f1c_len", fr_len[0], 88);
    chk("f1c_latency", fr_start[0] - a, 2);
    repeat (G + 4) @(posedge clk);

    // 0x00 then 0xFF back to back: parity 1 for both, gap exactly G
    push_byte(8'h00, a);
    push_byte(8'hFF, a);
    wait_frames(3, 600);
    chk("f00_byte", fr_b[1], 8'h00);
    chk("f00_par", fr_bits[1][9], 1'b1);
    chk("fff_byte", fr_b[2], 8'hFF);
    chk("fff_par", fr_bits[2][9], 1'b1);
    chk("gap_len", fr_start[2] - fr_end[1], G);
    repeat (G + 4) @(posedge clk);

    // inhibit held while filling the queue
    ps2_inhibit = 1'b1;
    f0 = nfalls_total;
    push_byte(8'hE0, a);
    push_byte(8'hF0, a);
    push_byte(8'h74, a);
    push_byte(8'h12, a);
    chk("full_ready", in_ready, 1'b0);
    chk("full_busy", busy, 1'b1);
    repeat (50) @(posedge clk);
    chk("inh_no_clk", nfalls_total - f0, 0);
    #1 ps2_inhibit = 1'b0;
    wait_frames(7, 2000);
    chk("q0", fr_b[3], 8'hE0);
    chk("q1", fr_b[4], 8'hF0);
    chk("q2", fr_b[5], 8'h74);
    chk("q3", fr_b[6], 8'h12);
    repeat (G + 4) @(posedge clk);

    // abort during bit index 5, resend after release
    push_byte(8'h1C, a);
    push_byte(8'h5A, a);
    wait_line(6, 1'b0, 500);
    ps2_inhibit = 1'b1;
    @(negedge clk);
    chk("abort_clk", ps2_clk, 1'b1);
    chk("abort_data", ps2_data, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rel = cyc;
    ps2_inhibit = 1'b0;
    wait_frames(9, 1000);
    chk("resend_byte", fr_b[7], 8'h1C);
    chk("resend_bits", fr_bits[7], 11'h438);
    chk("resend_time", fr_start[7] - rel, G + 1);
    chk("after_abort", fr_b[8], 8'h5A);
    repeat (G + 4) @(posedge clk);

    // inhibit during the stop bit: frame completes, nothing resent
    n0 = nframes;
    s0 = nstarts;
    push_byte(8'h3C, a);
    wait_line(10, 1'b1, 500);
    ps2_inhibit = 1'b1;
    repeat (60) @(posedge clk);
    chk("stop_done", nframes - n0, 1);
    chk("stop_byte", fr_b[n0], 8'h3C);
    #1 ps2_inhibit = 1'b0;
    repeat (60) @(posedge clk);
    chk("stop_noresend", nstarts - s0, 1);

    // reset mid-frame with two bytes queued
    push_byte(8'hA1, a);
    push_byte(8'hB2, a);
    push_byte(8'hC3, a);
    wait_line(3, 1'b1, 500);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_clk", ps2_clk, 1'b1);
    chk("mrst_data", ps2_data, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    s0 = nstarts;
    repeat (300) @(posedge clk);
    chk("mrst_noframe", nstarts - s0, 0);

    // randomized traffic with random inhibit bursts
    base = nframes;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          if ($urandom_range(0, 99) < 3) begin
            ps2_inhibit = 1'b1;
            repeat ($urandom_range(1, 30)) @(posedge clk);
            #1 ps2_inhibit = 1'b0;
          end
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          logic [7:0] rb;
          rb = 8'($urandom);
          push_byte(rb, a);
          sent.push_back(rb);
          repeat ($urandom_range(0, 120)) @(posedge clk);
        end
        rnd_on = 1'b0;
      end
    join
    wait_frames(base + 40, 30000);
    for (int i = 0; i < 40; i++) begin
      if (base + i < nframes) chk("rnd_byte", fr_b[base + i], sent[i]);
    end
    repeat (G + 4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
